// File: rtl/c_shift_pkg.sv
// c_shift_pkg: shared definitions for the serial shift / word collector blocks.
//   - bit-order codes latched by the accumulator on bit 0 of each word
//   - collector state enum
//   - word_len(): accepted bits per word, including the optional parity bit
// Optional feature macro: SHIFT_WORD_COLLECTOR_PARITY_EN (adds one even-parity bit per word).
package c_shift_pkg;

  localparam logic c_lsb_to_msb = 1'b0;
  localparam logic c_msb_to_lsb = 1'b1;

  typedef enum logic {COLLECT, HOLD} state_e;

`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
  localparam int unsigned c_par_bits = 1;
`else
  localparam int unsigned c_par_bits = 0;
`endif

  function automatic int unsigned word_len(input int unsigned width);
    return width + c_par_bits;
  endfunction

endpackage

// File: rtl/shift_word_acc.sv
// shift_word_acc: serial accumulator, bit counter and bit-order latch.
// Ports:
//   clk_i, sclr_n_i       clock, synchronous active-low reset
//   en_i                  a bit is accepted this cycle
//   bit_i, start_i        serial bit, restart-word qualifier
//   lsb_first_i           bit order, sampled on bit 0 only
//   done_o                strobe: the accepted bit completes a word
//   busy_o                a partial word is in progress (counter nonzero)
//   word_o / word_nxt_o   accumulator now / after this cycle's bit
//   par_o / par_nxt_o     running XOR of the word's bits (SHIFT_WORD_COLLECTOR_PARITY_EN)
module shift_word_acc
  import c_shift_pkg::*;
#(
  parameter int unsigned C_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               sclr_n_i,
  input  logic               en_i,
  input  logic               bit_i,
  input  logic               start_i,
  input  logic               lsb_first_i,
  output logic               done_o,
  output logic               busy_o,
  output logic [C_WIDTH-1:0] word_o,
  output logic [C_WIDTH-1:0] word_nxt_o
`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
  ,
  output logic               par_o,
  output logic               par_nxt_o
`endif
);

  localparam int unsigned     LEN   = word_len(C_WIDTH);
  localparam int unsigned     CW    = $clog2(LEN + 1);
  localparam logic [CW-1:0]   LEN_C = CW'(LEN);
  localparam logic [CW-1:0]   WID_C = CW'(C_WIDTH);

  logic [C_WIDTH-1:0] acc_q, acc_d, base;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic               dir_q, dir_d;
  logic               first;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    first   = start_i || (cnt_q == '0);
    // a restart throws away the partial word before inserting bit 0
    base    = start_i ? '0 : acc_q;
    cnt_inc = start_i ? CW'(1) : cnt_q + CW'(1);
    done_o  = en_i && (cnt_inc == LEN_C);
    if (en_i) begin
      if (first) dir_d = lsb_first_i ? c_lsb_to_msb : c_msb_to_lsb;
      // the trailing parity bit (index C_WIDTH) is counted but not stored
      if (start_i || (cnt_q < WID_C))
        acc_d = (dir_d == c_lsb_to_msb) ? {bit_i, base[C_WIDTH-1:1]}
                                        : {base[C_WIDTH-2:0], bit_i};
      cnt_d = done_o ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sclr_n_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      dir_q <= c_lsb_to_msb;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign busy_o     = (cnt_q != '0);
  assign word_o     = acc_q;
  assign word_nxt_o = acc_d;

`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (en_i) par_d = (first ? 1'b0 : par_q) ^ bit_i;
  end

  always_ff @(posedge clk_i) begin
    if (!sclr_n_i) par_q <= 1'b0;
    else           par_q <= par_d;
  end

  assign par_o     = par_q;
  assign par_nxt_o = par_d;
`endif

endmodule

// File: rtl/shift_word_collector.sv
// shift_word_collector: serial-to-parallel word collector behind the shift stage.
// Ports:
//   CLK, SCLR_N                         clock, synchronous active-low reset
//   SDIN, SDIN_VALID, SDIN_READY        serial input handshake (READY is registered)
//   FRAME_START                         accepted bit is bit 0 of a new word
//   LSB_FIRST                           bit order, sampled on bit 0
//   Q, Q_VALID, Q_READY                 buffered parallel output handshake
//   Q_PERR                              parity error for the word on Q
//   FRAME_ERR                           sticky: word restarted mid-assembly
// Optional feature macro: SHIFT_WORD_COLLECTOR_PARITY_EN (trailing even-parity bit per
// word; without it Q_PERR is tied 0).
module shift_word_collector
  import c_shift_pkg::*;
#(
  parameter int unsigned C_WIDTH       = 16,
  parameter bit          C_FRAME_CHECK = 1'b1
) (
  input  logic               CLK,
  input  logic               SCLR_N,
  input  logic               SDIN,
  input  logic               SDIN_VALID,
  output logic               SDIN_READY,
  input  logic               FRAME_START,
  input  logic               LSB_FIRST,
  output logic [C_WIDTH-1:0] Q,
  output logic               Q_VALID,
  input  logic               Q_READY,
  output logic               Q_PERR,
  output logic               FRAME_ERR
);

  state_e             state_q, state_d;
  logic               rdy_q, rdy_d;
  logic [C_WIDTH-1:0] q_q, q_d;
  logic               qv_q, qv_d;
  logic               ferr_q, ferr_d;
  logic               accept, consume, done, busy;
  logic               load_nxt, load_held;
  logic [C_WIDTH-1:0] word, word_nxt;

  assign accept  = SDIN_VALID && rdy_q;
  assign consume = qv_q && Q_READY;

  shift_word_acc #(.C_WIDTH(C_WIDTH)) u_acc (
    .clk_i       (CLK),
    .sclr_n_i    (SCLR_N),
    .en_i        (accept),
    .bit_i       (SDIN),
    .start_i     (FRAME_START),
    .lsb_first_i (LSB_FIRST),
    .done_o      (done),
    .busy_o      (busy),
    .word_o      (word),
    .word_nxt_o  (word_nxt)
`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
    ,
    .par_o       (par),
    .par_nxt_o   (par_nxt)
`endif
  );

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    qv_d      = qv_q;
    load_nxt  = 1'b0;
    load_held = 1'b0;
    ferr_d    = ferr_q | (C_FRAME_CHECK && accept && FRAME_START && busy);
    case (state_q)
      COLLECT: begin
        if (done) begin
          if (!qv_q || Q_READY) begin
            q_d      = word_nxt;
            qv_d     = 1'b1;
            load_nxt = 1'b1;
          end else begin
            // output still occupied: park the finished word in the accumulator
            state_d = HOLD;
          end
        end else if (consume) begin
          qv_d = 1'b0;
        end
      end
      HOLD: begin
        if (consume) begin
          q_d       = word;
          load_held = 1'b1;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    rdy_d = (state_d == COLLECT);
  end

  always_ff @(posedge CLK) begin
    if (!SCLR_N) begin
      state_q <= COLLECT;
      rdy_q   <= 1'b0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ferr_q  <= ferr_d;
    end
  end

  assign SDIN_READY = rdy_q;
  assign Q          = q_q;
  assign Q_VALID    = qv_q;
  assign FRAME_ERR  = ferr_q;

`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
  logic par, par_nxt;
  logic perr_q, perr_d;

  // parity flag travels with the word into Q
  always_comb begin
    perr_d = perr_q;
    if (load_nxt)       perr_d = par_nxt;
    else if (load_held) perr_d = par;
  end

  always_ff @(posedge CLK) begin
    if (!SCLR_N) perr_q <= 1'b0;
    else         perr_q <= perr_d;
  end

  assign Q_PERR = perr_q;
`else
  assign Q_PERR = 1'b0;
`endif

endmodule

// File: tb/tb_shift_word_collector.sv
module tb_shift_word_collector;

  localparam int W = 8;
`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
  localparam int LEN = W + 1;
`else
  localparam int LEN = W;
`endif

  logic         CLK = 1'b0;
  logic         SCLR_N = 1'b0;
  logic         SDIN = 1'b0;
  logic         SDIN_VALID = 1'b0;
  logic         FRAME_START = 1'b0;
  logic         LSB_FIRST = 1'b1;
  logic         Q_READY = 1'b0;
  logic         SDIN_READY, Q_VALID, Q_PERR, FRAME_ERR;
  logic [W-1:0] Q;

  int checks = 0;
  int errors = 0;

  shift_word_collector #(.C_WIDTH(W), .C_FRAME_CHECK(1'b1)) dut (
    .CLK         (CLK),
    .SCLR_N      (SCLR_N),
    .SDIN        (SDIN),
    .SDIN_VALID  (SDIN_VALID),
    .SDIN_READY  (SDIN_READY),
    .FRAME_START (FRAME_START),
    .LSB_FIRST   (LSB_FIRST),
    .Q           (Q),
    .Q_VALID     (Q_VALID),
    .Q_READY     (Q_READY),
    .Q_PERR      (Q_PERR),
    .FRAME_ERR   (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Output side modelled as a queue of finished words: entry 0 is Q, entry 1 is a
  // word parked because the output was occupied. Input is blocked while two are stored.
  logic [W-1:0] wq[$];
  logic         pq[$];
  logic         pb[LEN];
  int           plen = 0;
  logic         m_lf = 1'b1, m_ferr = 1'b0, m_rst = 1'b1, m_acc;
  logic [W-1:0] mw;
  logic         mp;

  always @(posedge CLK) begin
    if (!SCLR_N) begin
      wq.delete(); pq.delete();
      plen = 0; m_ferr = 1'b0; m_rst = 1'b1;
    end else begin
      m_acc = SDIN_VALID && !m_rst && (wq.size() < 2);
      if (wq.size() > 0 && Q_READY) begin
        void'(wq.pop_front()); void'(pq.pop_front());
      end
      if (m_acc) begin
        if (FRAME_START) begin
          if (plen != 0) m_ferr = 1'b1;
          plen = 0;
        end
        if (plen == 0) m_lf = LSB_FIRST;
        pb[plen] = SDIN;
        plen++;
        if (plen == LEN) begin
          mw = '0; mp = 1'b0;
          for (int i = 0; i < LEN; i++) mp ^= pb[i];
          for (int i = 0; i < W; i++)
            if (m_lf) mw[i] = pb[i]; else mw[W-1-i] = pb[i];
          wq.push_back(mw); pq.push_back(mp);
          plen = 0;
        end
      end
      m_rst = 1'b0;
    end
    #1;
    chk("m_q_valid", Q_VALID, wq.size() > 0);
    chk("m_sdin_ready", SDIN_READY, !m_rst && (wq.size() < 2));
    chk("m_frame_err", FRAME_ERR, m_ferr);
    if (wq.size() > 0) begin
      chk("m_q", Q, wq[0]);
`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
      chk("m_q_perr", Q_PERR, pq[0]);
`else
      chk("m_q_perr", Q_PERR, 1'b0);
`endif
    end
  end

  // ---------------- stimulus ----------------
`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
  logic par_flip = 1'b0;
`endif

  // drive a bit at the falling edge; it is accepted at the next rising edge with READY
  task automatic send_bit(input logic b, input logic fs, input logic lf);
    int n = 0;
    @(negedge CLK);
    SDIN = b; FRAME_START = fs; LSB_FIRST = lf; SDIN_VALID = 1'b1;
    while (!SDIN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=ready_low expected=ready_high t=%0t", $time);
    end
  endtask

  // send bits so the collected word equals v for the given order
  task automatic send_word(input logic [W-1:0] v, input logic lf, input logic fs);
    for (int i = 0; i < W; i++)
      send_bit(lf ? v[i] : v[W-1-i], (i == 0) ? fs : 1'b0, lf);
`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
    send_bit((^v) ^ par_flip, 1'b0, lf);
`endif
  endtask

  task automatic idle();
    @(negedge CLK);
    SDIN_VALID = 1'b0; FRAME_START = 1'b0;
  endtask

  task automatic post();
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q", Q, 0);
    chk("rst_q_valid", Q_VALID, 0);
    chk("rst_sdin_ready", SDIN_READY, 0);
    chk("rst_frame_err", FRAME_ERR, 0);
    chk("rst_q_perr", Q_PERR, 0);
    @(negedge CLK); SCLR_N = 1'b1; Q_READY = 1'b1;
    post();
    chk("ready_after_release", SDIN_READY, 1);

    // LSB-first: bits 1,0,1,1,0,0,1,0
    send_word(8'h4D, 1'b1, 1'b0);
    post();
    chk("lsb_q", Q, 8'h4D);
    chk("lsb_q_valid", Q_VALID, 1);
    idle(); post();
    chk("lsb_q_valid_1cyc", Q_VALID, 0);

    // MSB-first, same bit sequence
    send_word(8'hB2, 1'b0, 1'b0);
    post();
    chk("msb_q", Q, 8'hB2);
    idle();

    // back-pressure: two words with Q_READY low
    @(negedge CLK); Q_READY = 1'b0;
    send_word(8'h4D, 1'b1, 1'b0);
    send_word(8'h12, 1'b1, 1'b0);
    post();
    chk("bp_ready_low", SDIN_READY, 0);
    chk("bp_q_first", Q, 8'h4D);
    idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_q_stable", Q, 8'h4D);
    @(negedge CLK); Q_READY = 1'b1;
    post();
    chk("bp_q_second", Q, 8'h12);
    chk("bp_q_valid_kept", Q_VALID, 1);
    chk("bp_ready_back", SDIN_READY, 1);
    @(negedge CLK); Q_READY = 1'b1;
    post();
    chk("bp_drained", Q_VALID, 0);

    // frame restart on the 4th bit
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b1);
    send_word(8'h5A, 1'b1, 1'b1);
    post();
    chk("fr_q", Q, 8'h5A);
    chk("fr_frame_err", FRAME_ERR, 1);
    idle(); post();
    chk("fr_no_stale", Q_VALID, 0);

`ifdef SHIFT_WORD_COLLECTOR_PARITY_EN
    par_flip = 1'b0;
    send_word(8'h4D, 1'b1, 1'b0);
    post();
    chk("par_ok", Q_PERR, 0);
    idle();
    par_flip = 1'b1;
    send_word(8'h4D, 1'b1, 1'b0);
    post();
    chk("par_bad_q", Q, 8'h4D);
    chk("par_bad", Q_PERR, 1);
    idle();
    par_flip = 1'b0;
`endif

    // reset after 5 bits
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
    @(negedge CLK); SDIN_VALID = 1'b0; SCLR_N = 1'b0;
    @(negedge CLK); SCLR_N = 1'b1;
    post();
    chk("rm_q_valid", Q_VALID, 0);
    chk("rm_ready", SDIN_READY, 1);
    chk("rm_frame_err", FRAME_ERR, 0);
    send_word(8'hC3, 1'b0, 1'b0);
    post();
    chk("rm_clean_q", Q, 8'hC3);
    idle();

    // reset while in HOLD
    @(negedge CLK); Q_READY = 1'b0;
    send_word(8'hA1, 1'b1, 1'b0);
    send_word(8'h7E, 1'b1, 1'b0);
    idle();
    @(negedge CLK); SCLR_N = 1'b0;
    @(negedge CLK); SCLR_N = 1'b1; Q_READY = 1'b1;
    post();
    chk("rh_q_valid", Q_VALID, 0);
    chk("rh_ready", SDIN_READY, 1);
    send_word(8'h3C, 1'b1, 1'b0);
    post();
    chk("rh_clean_q", Q, 8'h3C);

    // throughput: back-to-back words, mixed order, Q_READY held high
    for (int k = 0; k < 4; k++)
      send_word(W'($urandom), k[0], 1'b0);
    idle();
    repeat (3) @(posedge CLK);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
